oscillator: RTL and testbench
=============================

Name: oscillator

Overview:
- Clock-generation block that derives the panel/system output clock `oclk` from the reference clock `clk`.
- Frequency is set by a programmable integer divisor, with near-50% duty cycle.
- Provides a single-cycle `tick` strobe in the `clk` domain and a `locked` flag once the output frequency has been stable.
- Sits at the top of the design and feeds the display driver's clock and shift logic.

Parameters:
- DIV_W, 8, width of the divisor input and internal counters.
- DEFAULT_DIV, 2, active divisor after reset, clamped to a minimum of 2.
- LOCK_CYCLES, 16, number of complete `oclk` periods with an unchanged divisor before `locked` asserts.

Ports:
- clk, input, 1, reference clock; all state updates on its rising edge.
- areset, input, 1, asynchronous active-low reset.
- en, input, 1, run enable; 0 parks `oclk` low.
- div, input, DIV_W, requested divisor N.
- oclk, output, 1, divided clock, registered (glitch-free).
- tick, output, 1, one-`clk`-cycle pulse on the cycle `oclk` rises.
- locked, output, 1, output frequency stable.

Behaviour:
- Reset: `areset`=0 asynchronously forces `oclk`=0, `tick`=0, `locked`=0, phase counter=0, lock counter=0, active divisor=max(DEFAULT_DIV,2). Reset mid-period aborts the period immediately.
- Divisor clamp: effective N = `div` if `div`>=2, else 2. Values 0 and 1 behave as 2.
- Sampling: `div` is sampled only at a period start, i.e. the edge where the phase counter goes to 0. Changes mid-period have no effect until the next period.
- Phase counter runs 0..N-1 and wraps to 0 after N-1.
- High time H = ceil(N/2).
  - `oclk` is registered as 1 while the counter is < H, and 0 otherwise.
  - The period is exactly N `clk` cycles.
  - Odd N gives one extra high cycle (e.g. N=3: 2 high, 1 low).
- `tick` is 1 in exactly the `clk` cycle in which `oclk` is 1 for the first time in a period, i.e. at counter 0. Otherwise 0.
- First edge after reset release with `en`=1 starts period 0: `oclk`=1, `tick`=1.
- Enable:
  - `en`=0 sampled at an edge: the next register values are `oclk`=0, `tick`=0, counter=0, `locked`=0, lock counter=0.
  - On the first edge with `en`=1 again, a fresh period starts (`oclk`=1, `tick`=1).
  - No partial high pulse is ever produced.
- Lock counter:
  - Increments at each period start that follows a complete period.
  - Saturates at LOCK_CYCLES.
  - `locked`=1 on the edge where the count reaches LOCK_CYCLES. With a constant N, that is the start of the (LOCK_CYCLES+1)-th period, i.e. LOCK_CYCLES*N cycles after the first tick.
- Divisor change:
  - If a clamped sampled `div` differs from the active divisor at a period start, the active divisor updates on that edge.
  - On the same edge the lock counter clears and `locked` drops to 0.
  - The new period uses the new N immediately.
  - Writing the same value has no effect on lock.
- Simultaneous events: reset beats all; `en`=0 beats a divisor change; a divisor change beats a lock increment.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then `en`=1, `div`=4 -> `oclk` pattern 1,1,0,0 repeating; `tick` high every 4th cycle starting at the first edge; `locked`=1 after 16 periods (64 cycles after first tick).
- `div`=3 -> `oclk` 1,1,0 repeating; `div`=0 and `div`=1 -> identical to `div`=2 (1,0 repeating).
- Change `div` 4->6 mid-period -> current 4-cycle period completes, then 3 high/3 low; `locked` drops at that period start and re-asserts after 16 periods of 6.
- Deassert `en` while `oclk`=1 -> `oclk`=0 at next edge, `locked`=0; reassert -> `oclk`=1 and `tick`=1 on the first enabled edge.
- Assert `areset`=0 asynchronously mid-period with `locked`=1 -> all outputs 0 immediately, without waiting for a `clk` edge; after release, active divisor=2 until the next period-start sample of `div`.
- Rewrite the same `div` value while locked -> `locked` stays 1; waveform unchanged.

Source files
------------

// File: rtl/oscillator.sv
// Programmable integer clock divider.
// Derives a registered, near-50% duty clock `oclk` from `clk`, with a
// one-cycle `tick` at each rising edge of `oclk` and a `locked` flag that
// asserts once the divisor has been stable for LOCK_CYCLES full periods.
module oscillator #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             oclk,
    output logic             tick,
    output logic             locked
);

    localparam int LCW        = $clog2(LOCK_CYCLES + 1);
    localparam int RST_DIV_I  = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
    localparam logic [DIV_W-1:0] RST_DIV  = RST_DIV_I[DIV_W-1:0];
    localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(2);
    localparam logic [LCW-1:0]   LOCK_MAX = LCW'(LOCK_CYCLES);

    logic [DIV_W-1:0] cnt_q, cnt_d;        // phase within the current period
    logic [DIV_W-1:0] div_q, div_d;        // active divisor N
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;
    logic             run_q, run_d;        // a period is in progress
    logic             oclk_q, oclk_d;
    logic             tick_q, tick_d;

    logic [DIV_W-1:0] div_clamp;
    logic             period_end;

    // Divisors below 2 cannot form a high and a low phase, so they run as 2.
    assign div_clamp  = (div < MIN_DIV) ? MIN_DIV : div;
    assign period_end = (cnt_q == div_q - DIV_W'(1));

    // Next-state: enable gate, period start (divisor sample + lock), or advance.
    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        run_d      = run_q;
        oclk_d     = 1'b0;
        tick_d     = 1'b0;
        if (!en) begin
            // Park low and forget lock; restart cleanly on re-enable.
            cnt_d      = '0;
            run_d      = 1'b0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (!run_q || period_end) begin
            // Period start: the only point where `div` is looked at.
            cnt_d  = '0;
            run_d  = 1'b1;
            oclk_d = 1'b1;
            tick_d = 1'b1;
            if (div_clamp != div_q) begin
                div_d      = div_clamp;
                lock_cnt_d = '0;
            end else if (run_q && lock_cnt_q != LOCK_MAX) begin
                // Only a period that actually completed counts toward lock.
                lock_cnt_d = lock_cnt_q + LCW'(1);
            end
            locked_d = (lock_cnt_d == LOCK_MAX);
        end else begin
            cnt_d  = cnt_q + DIV_W'(1);
            // High while phase < ceil(N/2), i.e. 2*phase < N.
            oclk_d = ({cnt_d, 1'b0} < {1'b0, div_q});
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            cnt_q      <= '0;
            div_q      <= RST_DIV;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            run_q      <= 1'b0;
            oclk_q     <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            run_q      <= run_d;
            oclk_q     <= oclk_d;
            tick_q     <= tick_d;
        end
    end

    assign oclk   = oclk_q;
    assign tick   = tick_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_oscillator.sv
// Bench for the oscillator divider: table-driven waveform vectors,
// hand-written lock/enable/reset sequences and a randomized run, all
// compared against a cycle-count based reference model.
module tb_oscillator;

    localparam int DIV_W = 8;
    localparam int LOCK  = 16;

    logic             clk = 1'b0;
    logic             areset = 1'b0;
    logic             en = 1'b0;
    logic [DIV_W-1:0] div = '0;
    logic             oclk, tick, locked;

    int pass_cnt = 0;
    int total_cnt = 0;

    oscillator #(.DIV_W(DIV_W), .DEFAULT_DIV(2), .LOCK_CYCLES(LOCK)) dut (
        .clk(clk), .areset(areset), .en(en), .div(div),
        .oclk(oclk), .tick(tick), .locked(locked)
    );

    always #5 clk = ~clk;

    // Reference model: absolute cycle count, start cycle of current period,
    // active N and number of completed same-N periods.
    int cyc = 0;
    int m_start = 0;
    int m_n = 2;
    bit m_run = 0;
    int m_stable = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    endtask

    task automatic model_reset();
        m_run = 0; m_n = 2; m_stable = 0;
    endtask

    task automatic model_edge();
        int req;
        cyc++;
        if (!areset) model_reset();
        else if (!en) begin
            m_run = 0; m_stable = 0;
        end else if (!m_run || (cyc - m_start) == m_n) begin
            req = (int'(div) < 2) ? 2 : int'(div);
            if (m_run) begin
                if (req != m_n) begin m_n = req; m_stable = 0; end
                else if (m_stable < LOCK) m_stable++;
            end else m_n = req;
            m_start = cyc;
            m_run = 1;
        end
    endtask

    // One clock edge: advance model, then compare all outputs just after it.
    task automatic step();
        int pos;
        @(posedge clk);
        model_edge();
        #1;
        pos = cyc - m_start;
        chk("model_oclk", oclk, m_run && (2 * pos < m_n));
        chk("model_tick", tick, m_run && (pos == 0));
        chk("model_locked", locked, m_stable == LOCK);
    endtask

    task automatic do_reset();
        areset = 1'b0; en = 1'b0;
        model_reset();
        step(); step();
        chk("rst_oclk", oclk, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_locked", locked, 1'b0);
        areset = 1'b1;
        step();
    endtask

    typedef struct {
        logic [DIV_W-1:0] dv;
        logic [11:0]      oclk_pat;
        logic [11:0]      tick_pat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [11:0] pat6;
        tbl[0] = '{8'd4, 12'b1100_1100_1100, 12'b1000_1000_1000};
        tbl[1] = '{8'd3, 12'b1101_1011_0110, 12'b1001_0010_0100};
        tbl[2] = '{8'd0, 12'b1010_1010_1010, 12'b1010_1010_1010};
        tbl[3] = '{8'd1, 12'b1010_1010_1010, 12'b1010_1010_1010};
        tbl[4] = '{8'd2, 12'b1010_1010_1010, 12'b1010_1010_1010};
        tbl[5] = '{8'd5, 12'b1110_0111_0011, 12'b1000_0100_0010};
        tbl[6] = '{8'd6, 12'b1110_0011_1000, 12'b1000_0010_0000};

        // Waveform table.
        foreach (tbl[k]) begin
            do_reset();
            en = 1'b1; div = tbl[k].dv;
            for (int i = 0; i < 12; i++) begin
                step();
                chk($sformatf("tbl%0d_oclk%0d", k, i), oclk, tbl[k].oclk_pat[11-i]);
                chk($sformatf("tbl%0d_tick%0d", k, i), tick, tbl[k].tick_pat[11-i]);
            end
        end

        // Lock timing with N=4, then change to 6 mid-period.
        do_reset();
        en = 1'b1; div = 8'd4;
        step();
        chk("lk_first_oclk", oclk, 1'b1);
        chk("lk_first_tick", tick, 1'b1);
        repeat (62) step();
        step(); chk("lk4_not_yet", locked, 1'b0);
        step(); chk("lk4_locked", locked, 1'b1); chk("lk4_tick", tick, 1'b1);
        step();
        div = 8'd6;
        step(); chk("chg_pos2", oclk, 1'b0);
        step(); chk("chg_pos3", oclk, 1'b0); chk("chg_still_lk", locked, 1'b1);
        step(); chk("chg_start_oclk", oclk, 1'b1); chk("chg_start_tick", tick, 1'b1);
        chk("chg_unlock", locked, 1'b0);
        pat6 = 12'b11000;
        for (int i = 0; i < 5; i++) begin
            step(); chk($sformatf("n6_pos%0d", i + 1), oclk, pat6[4-i]);
        end
        step(); chk("n6_tick2", tick, 1'b1);
        repeat (89) step();
        chk("lk6_not_yet", locked, 1'b0);
        step(); chk("lk6_locked", locked, 1'b1);

        // Same-value rewrite keeps lock.
        div = 8'd6;
        repeat (30) begin step(); chk("same_div_lk", locked, 1'b1); end
        chk("en_off_from_high", oclk, 1'b1);

        // Enable drop while high, then re-enable.
        en = 1'b0;
        step(); chk("en0_oclk", oclk, 1'b0); chk("en0_tick", tick, 1'b0);
        chk("en0_locked", locked, 1'b0);
        step(); chk("en0_oclk2", oclk, 1'b0);
        en = 1'b1;
        step(); chk("en1_oclk", oclk, 1'b1); chk("en1_tick", tick, 1'b1);
        repeat (96) step();
        chk("relock", locked, 1'b1);
        step();

        // Asynchronous reset mid-period while locked.
        #3 areset = 1'b0;
        #1;
        model_reset();
        chk("arst_oclk", oclk, 1'b0);
        chk("arst_tick", tick, 1'b0);
        chk("arst_locked", locked, 1'b0);
        div = 8'd5;
        #2 areset = 1'b1;
        pat6 = 12'b11100;
        for (int i = 0; i < 5; i++) begin
            step(); chk($sformatf("post_rst_oclk%0d", i), oclk, pat6[4-i]);
        end
        step(); chk("post_rst_tick", tick, 1'b1);

        // Randomized run.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) div = DIV_W'($urandom_range(0, 9));
            if ($urandom_range(0, 299) == 0) en = ~en;
            if (!en && $urandom_range(0, 19) == 0) en = 1'b1;
            if ($urandom_range(0, 999) == 0) begin
                #2 areset = 1'b0;
                #1;
                model_reset();
                chk("rnd_arst_oclk", oclk, 1'b0);
                chk("rnd_arst_locked", locked, 1'b0);
                #2 areset = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
